// File: rtl/serial_byte_loader.sv
// serial_byte_loader: serial-to-parallel front end of the byte register stage.
// Frames a serial bit stream on Start, assembles WIDTH qualified bits and
// presents the word on ByteOut with a one-cycle ByteValid pulse.
// Optional feature macro: PARITY_EN (one trailing even-parity bit per frame).
module serial_byte_loader #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic             SerIn,
   input  logic             SerValid,
   output logic             Busy,
   output logic [WIDTH-1:0] ByteOut,
   output logic             ByteValid,
   output logic             FrameErr,
   output logic             ParityErr
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] sr, sr_n;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] byte_n;
   logic             valid_n;
   logic             ferr_n;
`ifdef PARITY_EN
   logic             perr_q, perr_n;
`endif

   // Shift register contents with the current SerIn appended in bit order
   always_comb begin
      shifted = sr;
      if (MSB_FIRST != 0)
         shifted = {sr[WIDTH-2:0], SerIn};
      else
         shifted = {SerIn, sr[WIDTH-1:1]};
   end

   // Next-state, datapath and output pulse decode
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sr_n    = sr;
      byte_n  = ByteOut;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
`ifdef PARITY_EN
      perr_n  = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (Start) begin
               state_n = SHIFT;
               cnt_n   = '0;
               sr_n    = '0;
            end
         end
         SHIFT: begin
            if (Start) begin
               ferr_n = 1'b1;
               cnt_n  = '0;
               sr_n   = '0;
            end else if (SerValid) begin
               if (cnt == LAST) begin
                  cnt_n = '0;
`ifdef PARITY_EN
                  sr_n    = shifted;
                  state_n = PARITY;
`else
                  sr_n    = '0;
                  byte_n  = shifted;
                  valid_n = 1'b1;
                  state_n = IDLE;
`endif
               end else begin
                  sr_n  = shifted;
                  cnt_n = cnt + CW'(1);
               end
            end
         end
`ifdef PARITY_EN
         PARITY: begin
            if (Start) begin
               ferr_n  = 1'b1;
               cnt_n   = '0;
               sr_n    = '0;
               state_n = SHIFT;
            end else if (SerValid) begin
               byte_n  = sr;
               valid_n = 1'b1;
               perr_n  = ^{sr, SerIn};
               sr_n    = '0;
               state_n = IDLE;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   // State, datapath and registered outputs; reset wins over all inputs
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         sr        <= '0;
         Busy      <= 1'b0;
         ByteOut   <= '0;
         ByteValid <= 1'b0;
         FrameErr  <= 1'b0;
`ifdef PARITY_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         sr        <= sr_n;
         Busy      <= (state_n != IDLE);
         ByteOut   <= byte_n;
         ByteValid <= valid_n;
         FrameErr  <= ferr_n;
`ifdef PARITY_EN
         perr_q    <= perr_n;
`endif
      end
   end

`ifdef PARITY_EN
   assign ParityErr = perr_q;
`else
   assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
// Testbench for serial_byte_loader: an LSB-first and an MSB-first instance
// share one randomized serial stream; a scoreboard checks every delivered word.
module tb_serial_byte_loader;

   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] word;
      logic         perr;
   } exp_t;

   logic         Clock, Reset, Start, SerIn, SerValid;
   logic         busy_l, valid_l, ferr_l, perr_l;
   logic [W-1:0] out_l;
   logic         busy_m, valid_m, ferr_m, perr_m;
   logic [W-1:0] out_m;

   int   tests = 0;
   int   fails = 0;
   int   fe_exp = 0, fe_seen_l = 0, fe_seen_m = 0;
   bit   armed = 0;
   exp_t q_l[$];
   exp_t q_m[$];
   exp_t e_l, e_m;

   serial_byte_loader #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
      .Clock(Clock), .Reset(Reset), .Start(Start), .SerIn(SerIn), .SerValid(SerValid),
      .Busy(busy_l), .ByteOut(out_l), .ByteValid(valid_l), .FrameErr(ferr_l), .ParityErr(perr_l));

   serial_byte_loader #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
      .Clock(Clock), .Reset(Reset), .Start(Start), .SerIn(SerIn), .SerValid(SerValid),
      .Busy(busy_m), .ByteOut(out_m), .ByteValid(valid_m), .FrameErr(ferr_m), .ParityErr(perr_m));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever either instance presents a word
   always @(negedge Clock) begin
      if (armed) begin
         if (valid_l === 1'b1) begin
            if (q_l.size() == 0) check("unexpected_valid_lsb", 1, 0);
            else begin
               e_l = q_l.pop_front();
               check("word_lsb", 32'(out_l), 32'(e_l.word));
               check("perr_lsb", 32'(perr_l), 32'(e_l.perr));
            end
         end else check("perr_idle_lsb", 32'(perr_l), 0);
         if (valid_m === 1'b1) begin
            if (q_m.size() == 0) check("unexpected_valid_msb", 1, 0);
            else begin
               e_m = q_m.pop_front();
               check("word_msb", 32'(out_m), 32'(e_m.word));
               check("perr_msb", 32'(perr_m), 32'(e_m.perr));
            end
         end else check("perr_idle_msb", 32'(perr_m), 0);
         if (ferr_l === 1'b1) fe_seen_l++;
         if (ferr_m === 1'b1) fe_seen_m++;
      end
   end

   task automatic tick(input logic s, input logic d, input logic v);
      Start = s; SerIn = d; SerValid = v;
      @(posedge Clock);
      #1;
   endtask

   task automatic check_busy(input string name, input logic exp);
      check({name, "_l"}, 32'(busy_l), 32'(exp));
      check({name, "_m"}, 32'(busy_m), 32'(exp));
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick(1'($urandom), 1'($urandom), 1'($urandom));
      tick(1'($urandom), 1'($urandom), 1'($urandom));
      Reset = 1'b0;
      check_busy("rst_busy", 1'b0);
      check("rst_out_l", 32'(out_l), 0);
      check("rst_out_m", 32'(out_m), 0);
      check("rst_valid", 32'({valid_l, valid_m}), 0);
      check("rst_ferr", 32'({ferr_l, ferr_m}), 0);
   endtask

   task automatic gaps(input bit en);
      int unsigned n;
      n = en ? $urandom_range(0, 2) : 0;
      for (int unsigned g = 0; g < n; g++) begin
         tick(1'b0, 1'($urandom), 1'b0);
         check_busy("gap_busy", 1'b1);
      end
   endtask

   // Starts a frame and delivers k bits, leaving it unfinished
   task automatic partial(input int unsigned k);
      tick(1'b1, 1'($urandom), 1'($urandom));
      for (int unsigned i = 0; i < k; i++) tick(1'b0, 1'($urandom), 1'b1);
   endtask

   // seq[i] is the i-th transmitted data bit; abort_k>0 aborts after abort_k bits
   task automatic send_frame(input logic [W-1:0] seq, input bit gap_en,
                             input int unsigned abort_k, input logic pbit);
      exp_t xl, xm;
      int   ones;
      tick(1'b1, 1'($urandom), 1'($urandom));
      check_busy("start_busy", 1'b1);
      if (abort_k > 0) begin
         for (int unsigned i = 0; i < abort_k; i++) tick(1'b0, 1'($urandom), 1'b1);
         tick(1'b1, 1'($urandom), 1'b1);
         fe_exp++;
         check_busy("abort_busy", 1'b1);
      end
      xl.word = '0; xm.word = '0; ones = 0;
      for (int unsigned i = 0; i < W; i++) begin
         if (seq[i]) begin
            xl.word = xl.word + W'(1 << i);
            xm.word = xm.word + W'(1 << (W - 1 - i));
            ones++;
         end
      end
`ifdef PARITY_EN
      xl.perr = 1'((ones + int'(pbit)) % 2);
`else
      xl.perr = 1'b0;
`endif
      xm.perr = xl.perr;
      q_l.push_back(xl);
      q_m.push_back(xm);
      for (int unsigned i = 0; i < W; i++) begin
         gaps(gap_en);
         tick(1'b0, seq[i], 1'b1);
`ifdef PARITY_EN
         check_busy("bit_busy", 1'b1);
`else
         check_busy("bit_busy", (i == W - 1) ? 1'b0 : 1'b1);
`endif
      end
`ifdef PARITY_EN
      gaps(gap_en);
      tick(1'b0, pbit, 1'b1);
      check_busy("par_busy", 1'b0);
`endif
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; SerIn = 1'b0; SerValid = 1'b0;
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      Reset = 1'b0;
      armed = 1;
      tick(1'b0, 1'b0, 1'b0);
      check_busy("init_busy", 1'b0);

      // Reset in the middle of a frame, then after 5 of 8 bits
      partial(3);
      do_reset();
      partial(5);
      do_reset();
      tick(1'b0, 1'b0, 1'b0);

      // A5 LSB first (stream 1,0,1,0,0,1,0,1), without and with gaps
      send_frame(8'hA5, 0, 0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      send_frame(8'hA5, 1, 0, 1'b1);
      // Abort after 3 bits, then a full 3C
      send_frame(8'h3C, 0, 3, 1'b0);
      // Back-to-back frames 01 and 80 with no idle cycle
      send_frame(8'h01, 0, 0, 1'b1);
      send_frame(8'h80, 0, 0, 1'b0);
`ifdef PARITY_EN
      send_frame(8'hA5, 0, 0, 1'b0);
      send_frame(8'hA5, 0, 0, 1'b1);
`endif

      // Randomized frames with gaps, aborts and arbitrary parity bits
      for (int unsigned n = 0; n < 40; n++) begin
         send_frame(W'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : 0,
                    1'($urandom));
         if ($urandom_range(0, 1) == 0) tick(1'b0, 1'($urandom), 1'($urandom));
      end

      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      do_reset();
      tick(1'b0, 1'b0, 1'b0);

      check("ferr_count_l", 32'(fe_seen_l), 32'(fe_exp));
      check("ferr_count_m", 32'(fe_seen_m), 32'(fe_exp));
      check("pending_l", 32'(q_l.size()), 0);
      check("pending_m", 32'(q_m.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
